// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: issues one halfword-addressed read per
// instruction and presents each fetched word to decode over valid/ready.
// Advances the PC by 1 halfword for a compressed instruction and by 2 for a
// full-width one. A redirect overrides the sequential PC in the same cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fetch_en            allow new memory requests
//   redirect_valid/pc   restart fetch at redirect_pc, dropping the current instr
//   instr_valid/ready   handshake to decode
//   instr_data/pc       presented word (bits[15:0] at instr_pc) and its address
//   imem_ceb/web/A/Q    instruction memory port (ceb active-low, web held at 1)
module ifetch_ctrl #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  imem_ceb,
    output logic                  imem_web,
    output logic [ADDR_WIDTH-1:0] imem_A,
    input  logic [31:0]           imem_Q
);

    localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_PC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]             hold_q, hold_d;
    logic [31:0]             cur_data;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    req;
    logic [ADDR_WIDTH-1:0]   req_addr;

    // Word currently presented to decode and the sequential PC that follows it
    always_comb begin
        cur_data = (state_q == HOLD) ? hold_q : imem_Q;
        next_pc  = pc_q + ((cur_data[1:0] == 2'b11) ? ADDR_WIDTH'(2) : ADDR_WIDTH'(1));
    end

    // Next-state, memory request and handshake outputs
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_d      = hold_q;
        req         = 1'b0;
        req_addr    = '0;
        instr_valid = 1'b0;
        instr_data  = '0;
        instr_pc    = pc_q;

        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    req      = 1'b1;
                    req_addr = pc_q;
                    state_d  = RESP;
                end
            end
            RESP, HOLD: begin
                instr_valid = 1'b1;
                instr_data  = cur_data;
                if (instr_ready) begin
                    pc_d = next_pc;
                    if (fetch_en) begin
                        req      = 1'b1;
                        req_addr = next_pc;
                        state_d  = RESP;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    // Capture the read data: memory output is only valid for one cycle
                    hold_d  = cur_data;
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect wins over everything, including a completing handshake
        if (redirect_valid) begin
            instr_valid = 1'b0;
            pc_d        = redirect_pc;
            hold_d      = hold_q;
            req         = fetch_en;
            req_addr    = fetch_en ? redirect_pc : '0;
            state_d     = fetch_en ? RESP : IDLE;
        end
    end

    // No request may reach memory while reset is asserted
    always_comb begin
        imem_ceb = ~(req & rst_n);
        imem_A   = (req & rst_n) ? req_addr : '0;
        imem_web = 1'b1;
    end

    // State, PC and hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RST_PC;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer that drives the 32-bit, halfword-addressed instruction memory and delivers one instruction at a time to decode over a valid/ready handshake. It tracks the fetch PC in halfwords and issues one read per instruction. It advances the PC by 1 halfword for a compressed instruction and by 2 halfwords for a full-width one. A redirect input (branch, trap or fast-interrupt vector) overrides the sequential PC with single-cycle turnaround.

Parameters:
ADDR_WIDTH, 10, width of the halfword address (matches instruction-memory A port)
RESET_PC, 0, halfword address of the first fetch after reset

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_en  input  1  1 = new memory requests may be issued; 0 = issue no new requests
redirect_valid  input  1  pulse: discard the current instruction and restart fetch at redirect_pc
redirect_pc  input  ADDR_WIDTH  halfword target address for the redirect
instr_valid  output  1  instr_data and instr_pc are valid
instr_ready  input  1  decode accepts the instruction this cycle
instr_data  output  32  raw memory word; bits[15:0] hold the instruction at instr_pc
instr_pc  output  ADDR_WIDTH  halfword address of instr_data
imem_ceb  output  1  memory chip enable, active-low
imem_web  output  1  memory read/write select; held at 1 (read)
imem_A  output  ADDR_WIDTH  memory halfword address
imem_Q  input  32  memory read data; valid the cycle after a request with imem_ceb=0

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, pc_q=RESET_PC, hold_q=0.
  - instr_valid=0, instr_data=0, instr_pc=RESET_PC.
  - imem_ceb=1, imem_web=1, imem_A=0.
  - Reset asserted mid-operation abandons any outstanding read. No instruction is presented until a new request returns.
- Instruction length:
  - len = 2 if instr_data[1:0]==2'b11, else len = 1.
  - next_pc = (pc_q + len) mod 2^ADDR_WIDTH; wrap-around is silent.
- States:
  - IDLE: no request, instr_valid=0. If fetch_en=1, drive imem_ceb=0, imem_A=pc_q; next state RESP.
  - RESP: read data present.
    - instr_valid=1, instr_data=imem_Q, instr_pc=pc_q.
    - If instr_ready=1 and fetch_en=1: same-cycle request at next_pc (imem_ceb=0, imem_A=next_pc), pc_q<=next_pc, stay in RESP. Throughput is 1 instruction/cycle.
    - If instr_ready=1 and fetch_en=0: pc_q<=next_pc, go to IDLE.
    - If instr_ready=0: hold_q<=imem_Q, imem_ceb=1, go to HOLD.
  - HOLD: instr_valid=1, instr_data=hold_q, instr_pc=pc_q. Memory is idle.
    - On instr_ready=1 with fetch_en=1: request next_pc, pc_q<=next_pc, go to RESP.
    - On instr_ready=1 with fetch_en=0: pc_q<=next_pc, go to IDLE.
- Output stability: while instr_valid=1 and instr_ready=0, instr_data and instr_pc must not change.
- imem_A and imem_ceb are combinational from state, pc_q, imem_Q and the inputs. imem_A=0 whenever imem_ceb=1.
- Redirect (highest priority, any state):
  - In the cycle redirect_valid=1: instr_valid is forced to 0, so no handshake completes.
  - pc_q<=redirect_pc.
  - If fetch_en=1: imem_ceb=0, imem_A=redirect_pc, next state RESP. Otherwise next state IDLE.
  - A redirect in the same cycle as instr_ready=1 takes precedence; the presented instruction is dropped.
  - Back-to-back redirects: the last one wins.
- fetch_en=0 never drops an instruction already presented; it only blocks new requests.
- imem_web is constant 1. The instruction memory is never written by this block.

Test Plan:
- Reset release with fetch_en=1, instr_ready=1, memory holding 32-bit words at halfwords 0,2,4 -> request at A=0 in the first cycle; instr_pc sequence 0,2,4 on consecutive cycles; instr_valid stays high.
- Mixed lengths: a 16-bit instruction at halfword 0 (bits[1:0]=01), then a 32-bit instruction at halfword 1 -> instr_pc 0, then 1, then 3; imem_A sequence 0,1,3.
- Backpressure: instr_ready=0 for 3 cycles while instr_pc=4 -> imem_ceb=1 during the stall; instr_data and instr_pc constant; on ready, request at 6 with no duplicate or skipped instruction.
- Redirect: redirect_valid=1 with redirect_pc=0x100 while a valid instruction is held and instr_ready=1 -> instr_valid=0 that cycle; imem_A=0x100; next instr_pc=0x100.
- Wrap: a 32-bit instruction at halfword 0x3FF -> next request at A=0x001.
- rst_n low mid-stream in HOLD -> instr_valid drops to 0 immediately; after release, fetch restarts at RESET_PC.
